seg34_marquee_ctrl: RTL and testbench
=====================================

// Module: seg34_marquee_ctrl
// PURPOSE
// Sequencer that shares one 34-segment character renderer across N_SLOTS character
//   positions on a scanline and scrolls a stored message across them.
// Stores up to MSG_LEN 34-bit segment patterns, written through a valid/ready port.
// Per pixel, drives the renderer's posx/posy/segments. Advances the scroll offset
//   only on a frame tick in vertical blanking, so a visible frame never tears.
// PARAMETERS
// SG_WD         5    segment width; must match the renderer
// DL            100  display length; must match the renderer
// GAP           10   horizontal pixels between adjacent characters
// X0            20   left x of slot 0
// Y0            20   top y of all slots
// N_SLOTS       6    visible character slots
// MSG_LEN       16   message buffer depth (power of 2)
// SCROLL_FRAMES 30   frame ticks per scroll step (>=1)
// FRAME_LINE    480  VCOUNT value that defines the frame tick (blanking line)
// PORTS
// clk       in   1   pixel clock; HCOUNT advances by 1 per clk
// rst       in   1   asynchronous active-high reset
// HCOUNT    in   11  horizontal counter
// VCOUNT    in   11  vertical counter
// wr_valid  in   1   write request
// wr_data   in   34  segment pattern to append
// wr_ready  out  1   write accept
// start     in   1   pulse: LOAD->RUN
// stop      in   1   pulse: RUN->LOAD
// clear     in   1   pulse: empty the buffer
// posx      out  11  renderer X for the current slot
// posy      out  11  renderer Y (= Y0)
// segments  out  34  renderer segment vector; 0 = blank
// HCOUNT_D  out  11  HCOUNT delayed 1 clk; feed to the renderer
// VCOUNT_D  out  11  VCOUNT delayed 1 clk; feed to the renderer
// busy      out  1   1 in RUN
// BEHAVIOUR
// Geometry: VB=(DL-5*SG_WD)/4, HB=VB+SG_WD, CW=2*HB+3*SG_WD, P=CW+GAP.
//   Defaults: VB=18, HB=23, CW=61, P=71.
// Slot i covers HCOUNT in [X0+i*P, X0+(i+1)*P-1], with posx=X0+i*P.
// Reset: all outputs 0; state EMPTY; count=0; offset=0; frame counter=0.
// States:
//   EMPTY (count==0) -> LOAD on an accepted write.
//   LOAD -> RUN on start; start is ignored in EMPTY.
//   RUN -> LOAD on stop; offset is retained.
//   Any state -> EMPTY on clear (count=0, offset=0).
//   Priority: clear > stop > start > write.
// wr_ready = !rst && !clear && state!=RUN && count<MSG_LEN (combinational).
// Write: on wr_valid&&wr_ready, buf[count]<=wr_data and count++. When count==MSG_LEN,
//   wr_ready=0 and the write is held off.
// Pixel path (1-clk latency, registered):
//   Inputs: HCOUNT/VCOUNT sampled at cycle t.
//   At t+1: posx = slot base, posy = Y0, and segments = buf[(offset+i) mod count]
//     for slot i, when i<count and Y0<=VCOUNT<=Y0+DL.
//   Otherwise segments=0, and posx holds its last value.
//   Also 0 for HCOUNT<X0 or HCOUNT>=X0+N_SLOTS*P. In EMPTY, segments=0 everywhere.
//   HCOUNT_D/VCOUNT_D are the same-cycle delayed copies.
// Frame tick: single cycle with HCOUNT==0 && VCOUNT==FRAME_LINE.
// Scrolling, in RUN only:
//   The frame counter increments on each tick. At SCROLL_FRAMES-1 it resets and
//     offset <= (offset+1==count) ? 0 : offset+1.
//   start clears the frame counter. The counter is frozen outside RUN.
// Offset changes only at a frame tick, except on clear.
// The modulo index is computed by compare/subtract; no divider (offset<count, i<N_SLOTS).
// rst mid-frame: outputs go to 0 immediately (async), and the buffer contents are
//   don't-care.
// TESTING
// T1 reset: assert rst in RUN -> segments=0, busy=0; after release wr_ready=1 and
//   state EMPTY.
// T2 pixel select: write 34'h1, 34'h2, 34'h3, stay in LOAD; drive HCOUNT=96, VCOUNT=50
//   -> next clk segments=34'h2, posx=91, posy=20.
// T3 full: write 16 patterns -> wr_ready=0 after the 16th; a 17th wr_valid is held
//   and count stays 16.
// T4 scroll: SCROLL_FRAMES=2, count=3, start -> after 2 ticks slot0 shows 34'h2,
//   slot1 shows 34'h3, slot2 shows 34'h1; after 6 ticks offset=0; wr_ready=0 in RUN.
// T5 simultaneous: clear+start+wr_valid in the same clk -> EMPTY, count=0, no write,
//   busy=0.
// T6 bounds: HCOUNT=446 or VCOUNT=19 or VCOUNT=121 -> segments=0; HCOUNT=445,
//   VCOUNT=20 with count>=6 -> slot5 pattern.

Source files
------------

// File: rtl/seg34_marquee_ctrl.sv
// seg34_marquee_ctrl
//   Shares one 34-segment character renderer across N_SLOTS character positions on a
//   scanline and scrolls a stored message across them. Patterns are appended through a
//   valid/ready port. The scroll offset only moves on the blanking-line frame tick, so a
//   visible frame is always drawn from a single offset.
//
// Ports
//   clk, rst            pixel clock, asynchronous active-high reset
//   HCOUNT, VCOUNT      raster position, HCOUNT advances once per clk
//   wr_valid/wr_data    append request and 34-bit segment pattern
//   wr_ready            append accept (combinational)
//   start, stop, clear  control pulses: LOAD->RUN, RUN->LOAD, empty the buffer
//   posx, posy          renderer origin for the slot under the beam (registered)
//   segments            renderer segment vector, 0 = blank (registered)
//   HCOUNT_D, VCOUNT_D  raster position delayed to line up with posx/posy/segments
//   busy                high while scrolling (RUN)

module seg34_marquee_ctrl #(
  parameter int unsigned SG_WD         = 5,
  parameter int unsigned DL            = 100,
  parameter int unsigned GAP           = 10,
  parameter int unsigned X0            = 20,
  parameter int unsigned Y0            = 20,
  parameter int unsigned N_SLOTS       = 6,
  parameter int unsigned MSG_LEN       = 16,
  parameter int unsigned SCROLL_FRAMES = 30,
  parameter int unsigned FRAME_LINE    = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] HCOUNT,
  input  logic [10:0] VCOUNT,
  input  logic        wr_valid,
  input  logic [33:0] wr_data,
  output logic        wr_ready,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  output logic [10:0] posx,
  output logic [10:0] posy,
  output logic [33:0] segments,
  output logic [10:0] HCOUNT_D,
  output logic [10:0] VCOUNT_D,
  output logic        busy
);

  // Character geometry; must agree with the renderer's own derivation.
  localparam int unsigned Vb    = (DL - 5 * SG_WD) / 4;
  localparam int unsigned Hb    = Vb + SG_WD;
  localparam int unsigned Cw    = 2 * Hb + 3 * SG_WD;
  localparam int unsigned Pitch = Cw + GAP;

  localparam int unsigned AddrW  = $clog2(MSG_LEN);
  localparam int unsigned CntW   = AddrW + 1;
  localparam int unsigned SlotW  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int unsigned FrameW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  typedef enum logic [1:0] {
    StEmpty,
    StLoad,
    StRun
  } state_e;

  state_e              state_q;
  logic [CntW-1:0]     count_q;
  logic [AddrW-1:0]    offset_q;
  logic [FrameW-1:0]   frame_q;
  logic [33:0]         msg_q [MSG_LEN];

  logic                wr_fire;
  logic                frame_tick;

  // ---------------------------------------------------------------------------------
  // Write handshake
  // ---------------------------------------------------------------------------------
  assign wr_ready = !rst && !clear && (state_q != StRun) && (count_q < CntW'(MSG_LEN));
  assign wr_fire  = wr_valid && wr_ready;
  assign busy     = (state_q == StRun);

  assign frame_tick = (HCOUNT == 11'd0) && (VCOUNT == 11'(FRAME_LINE));

  // Buffer contents are not reset; only count_q says which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      msg_q[count_q[AddrW-1:0]] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------------
  // Control FSM, message count, scroll offset and frame counter
  // ---------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StEmpty;
      count_q  <= '0;
      offset_q <= '0;
      frame_q  <= '0;
    end else if (clear) begin
      state_q  <= StEmpty;
      count_q  <= '0;
      offset_q <= '0;
    end else if (stop && (state_q == StRun)) begin
      // Offset is kept so a later start resumes where the scroll left off.
      state_q <= StLoad;
    end else begin
      if ((state_q == StRun) && frame_tick) begin
        if (frame_q == FrameW'(SCROLL_FRAMES - 1)) begin
          frame_q  <= '0;
          offset_q <= (({1'b0, offset_q} + 1'b1) == count_q) ? '0 : offset_q + 1'b1;
        end else begin
          frame_q <= frame_q + 1'b1;
        end
      end
      if (start && (state_q == StLoad)) begin
        state_q <= StRun;
        frame_q <= '0;
      end
      if (wr_fire) begin
        count_q <= count_q + 1'b1;
        if (state_q == StEmpty) begin
          state_q <= StLoad;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------
  // Pixel path: find the slot under HCOUNT and the message entry it shows
  // ---------------------------------------------------------------------------------
  logic [31:0]      hc32;
  logic [31:0]      vc32;
  logic             slot_hit;
  logic [SlotW-1:0] slot_idx;
  logic [10:0]      slot_base;
  logic             vert_in;
  logic [CntW-1:0]  slot_ext;
  logic [CntW-1:0]  idx_sum;
  logic [CntW-1:0]  idx_mod;
  logic             show;

  assign hc32 = {21'd0, HCOUNT};
  assign vc32 = {21'd0, VCOUNT};

  always_comb begin
    slot_hit  = 1'b0;
    slot_idx  = '0;
    slot_base = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if ((hc32 >= X0 + i * Pitch) && (hc32 < X0 + (i + 1) * Pitch)) begin
        slot_hit  = 1'b1;
        slot_idx  = SlotW'(i);
        slot_base = 11'(X0 + i * Pitch);
      end
    end
  end

  assign vert_in  = (vc32 >= Y0) && (vc32 <= Y0 + DL);
  assign slot_ext = CntW'(slot_idx);

  // offset < count and slot < count, so the sum is below 2*count and one conditional
  // subtract gives the modulo.
  assign idx_sum = {1'b0, offset_q} + slot_ext;
  assign idx_mod = (idx_sum >= count_q) ? (idx_sum - count_q) : idx_sum;

  assign show = (state_q != StEmpty) && slot_hit && vert_in && (slot_ext < count_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      posx     <= '0;
      posy     <= '0;
      segments <= '0;
      HCOUNT_D <= '0;
      VCOUNT_D <= '0;
    end else begin
      HCOUNT_D <= HCOUNT;
      VCOUNT_D <= VCOUNT;
      if (show) begin
        posx     <= slot_base;
        posy     <= 11'(Y0);
        segments <= msg_q[idx_mod[AddrW-1:0]];
      end else begin
        // posx/posy hold so the renderer origin does not jump in blank regions.
        segments <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seg34_marquee_ctrl.sv
// Self-checking bench for seg34_marquee_ctrl: directed scenarios followed by random
// stimulus, all compared against a queue-based reference model.

module tb_seg34_marquee_ctrl;

  localparam int SF  = 2;
  localparam int SGW = 5;
  localparam int DLN = 100;
  localparam int GP  = 10;
  localparam int X0  = 20;
  localparam int Y0  = 20;
  localparam int NS  = 6;
  localparam int ML  = 16;
  localparam int FL  = 480;
  localparam int VB  = (DLN - 5 * SGW) / 4;
  localparam int HB  = VB + SGW;
  localparam int CW  = 2 * HB + 3 * SGW;
  localparam int P   = CW + GP;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] HCOUNT, VCOUNT;
  logic        wr_valid;
  logic [33:0] wr_data;
  logic        wr_ready;
  logic        start, stop, clear;
  logic [10:0] posx, posy, HCOUNT_D, VCOUNT_D;
  logic [33:0] segments;
  logic        busy;

  seg34_marquee_ctrl #(
    .SCROLL_FRAMES(SF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .HCOUNT   (HCOUNT),
    .VCOUNT   (VCOUNT),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .posx     (posx),
    .posy     (posy),
    .segments (segments),
    .HCOUNT_D (HCOUNT_D),
    .VCOUNT_D (VCOUNT_D),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model
  typedef enum int {MEmpty, MLoad, MRun} mstate_e;
  mstate_e     m_state;
  logic [33:0] m_msg[$];
  int          m_off;
  int          m_fc;
  logic [33:0] e_seg;
  logic [10:0] e_posx, e_posy, e_hd, e_vd;

  logic [33:0] w [ML];

  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = MEmpty;
    m_msg.delete();
    m_off  = 0;
    m_fc   = 0;
    e_seg  = '0;
    e_posx = '0;
    e_posy = '0;
    e_hd   = '0;
    e_vd   = '0;
  endtask

  // Apply one clock of stimulus, then check every output against the model.
  task automatic cycle(input int h, input int v, input logic wv, input logic [33:0] wd,
                       input logic st, input logic sp, input logic cl);
    logic exp_rdy;
    int   cnt;
    int   slot;
    logic tick;
    HCOUNT   = 11'(h);
    VCOUNT   = 11'(v);
    wr_valid = wv;
    wr_data  = wd;
    start    = st;
    stop     = sp;
    clear    = cl;
    cnt      = m_msg.size();
    exp_rdy  = !cl && (m_state != MRun) && (cnt < ML);
    #1;
    chk("wr_ready", 34'(wr_ready), 34'(exp_rdy));
    @(posedge clk);
    if (m_state != MEmpty && h >= X0 && h < X0 + NS * P && v >= Y0 && v <= Y0 + DLN &&
        (h - X0) / P < cnt) begin
      slot   = (h - X0) / P;
      e_seg  = m_msg[(m_off + slot) % cnt];
      e_posx = 11'(X0 + slot * P);
      e_posy = 11'(Y0);
    end else begin
      e_seg = '0;
    end
    e_hd = 11'(h);
    e_vd = 11'(v);
    tick = (h == 0) && (v == FL);
    if (cl) begin
      m_state = MEmpty;
      m_msg.delete();
      m_off = 0;
    end else if (sp && m_state == MRun) begin
      m_state = MLoad;
    end else begin
      if (m_state == MRun && tick) begin
        m_fc++;
        if (m_fc == SF) begin
          m_fc  = 0;
          m_off = (m_off + 1) % cnt;
        end
      end
      if (st && m_state == MLoad) begin
        m_state = MRun;
        m_fc    = 0;
      end
      if (wv && exp_rdy) begin
        m_msg.push_back(wd);
        if (m_state == MEmpty) m_state = MLoad;
      end
    end
    #1;
    chk("segments", segments, e_seg);
    chk("posx", 34'(posx), 34'(e_posx));
    chk("posy", 34'(posy), 34'(e_posy));
    chk("hcount_d", 34'(HCOUNT_D), 34'(e_hd));
    chk("vcount_d", 34'(VCOUNT_D), 34'(e_vd));
    chk("busy", 34'(busy), 34'(m_state == MRun));
  endtask

  task automatic idle();
    cycle(600, 600, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [33:0] d);
    cycle(600, 600, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    cycle(0, FL, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pix(input int h, input int v);
    cycle(h, v, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    wr_valid = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    clear    = 1'b0;
    rst      = 1'b1;
    #1;
    chk("rst_segments", segments, '0);
    chk("rst_busy", 34'(busy), '0);
    chk("rst_posx", 34'(posx), '0);
    chk("rst_wr_ready", 34'(wr_ready), '0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rel_wr_ready", 34'(wr_ready), 34'd1);
    chk("rel_busy", 34'(busy), '0);
  endtask

  initial begin
    int r, h, v;
    int vsel [6];
    logic wv, st, sp, cl;
    vsel = '{19, 20, 60, 120, 121, FL};
    rst = 1'b0; HCOUNT = '0; VCOUNT = '0; wr_valid = 1'b0; wr_data = '0;
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    model_reset();
    #2;
    do_reset();

    // Pixel select in LOAD
    wr(34'h1); wr(34'h2); wr(34'h3);
    pix(96, 50);
    chk("t2_seg", segments, 34'h2);
    chk("t2_posx", 34'(posx), 34'd91);
    chk("t2_posy", 34'(posy), 34'd20);
    pix(96, 200);
    chk("t2_blank_posx_hold", 34'(posx), 34'd91);

    // Scroll
    cycle(600, 600, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("t4_rdy_run", 34'(wr_ready), '0);
    tick(); idle(); tick();
    pix(X0 + 5, 50);         chk("t4_slot0", segments, 34'h2);
    pix(X0 + P + 5, 50);     chk("t4_slot1", segments, 34'h3);
    pix(X0 + 2 * P + 5, 50); chk("t4_slot2", segments, 34'h1);
    repeat (4) tick();
    pix(X0 + 5, 50);         chk("t4_wrap", segments, 34'h1);
    cycle(600, 600, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    tick(); tick();
    pix(X0 + 5, 50);         chk("stop_frozen", segments, 34'h1);

    // Reset in RUN
    cycle(600, 600, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    pix(X0 + 5, 50);
    do_reset();

    // Simultaneous clear + start + write
    wr(34'h55);
    cycle(600, 600, 1'b1, 34'h77, 1'b1, 1'b0, 1'b1);
    chk("t5_busy", 34'(busy), '0);
    pix(X0 + 5, 50);         chk("t5_empty_seg", segments, '0);
    wr(34'hA);
    pix(X0 + 5, 50);         chk("t5_first", segments, 34'hA);
    pix(X0 + P + 5, 50);     chk("t5_count1", segments, '0);

    // Full buffer
    cycle(600, 600, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < ML; i++) begin
      w[i] = 34'({$urandom(), $urandom()}) | 34'h1;
      wr(w[i]);
    end
    chk("t3_full", 34'(wr_ready), '0);
    wr(34'h3_0000_0000);
    for (int i = 0; i < NS; i++) begin
      pix(X0 + i * P + 7, 20);
      chk("t3_slot", segments, w[i]);
    end

    // Bounds
    pix(446, 50);  chk("t6_h446", segments, '0);
    pix(445, 20);  chk("t6_h445", segments, w[5]);
    pix(445, 19);  chk("t6_v19", segments, '0);
    pix(445, 121); chk("t6_v121", segments, '0);
    pix(445, 120); chk("t6_v120", segments, w[5]);
    pix(19, 50);   chk("t6_h19", segments, '0);

    // Scroll with 16 entries: full revolution needs 32 ticks
    cycle(600, 600, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    pix(X0 + 1, 50); chk("t3_scroll1", segments, w[1]);
    repeat (30) tick();
    pix(X0 + 1, 50); chk("t3_scroll_wrap", segments, w[0]);
    cycle(600, 600, 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      r  = $urandom_range(0, 99);
      h  = $urandom_range(0, 520);
      v  = vsel[$urandom_range(0, 5)];
      if (r < 12) begin
        h = 0;
        v = FL;
      end
      cl = (r == 99);
      sp = (r >= 95) && (r <= 97);
      st = (r >= 88) && (r <= 94);
      wv = ($urandom_range(0, 3) == 0);
      cycle(h, v, wv, 34'({$urandom(), $urandom()}), st, sp, cl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
